// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//
// Forwarding and load-use hazard unit for the pipelined LEGv8 core. It keeps
// a shadow pipeline of writer tags (valid, rd, regwrite, is_load) that is
// FWD_DEPTH stages deep. Stage 0 mirrors EX/MEM, stage 1 mirrors MEM/WB, and
// so on. The instruction currently in EX is compared against those tags.
//
// Ports:
//   clk, reset        : clock; synchronous active-high reset
//   ex_valid          : EX holds a real instruction (not a bubble)
//   ex_rd             : destination register of the EX instruction
//   ex_regwrite       : EX instruction writes ex_rd
//   ex_is_load        : EX instruction is a load
//   ex_src            : NUM_SRC packed source register indices
//   ex_src_used       : per-source "actually read" flags
//   ext_hold          : global pipeline freeze; tags hold
//   flush             : kill the EX instruction; suppresses stall
//   fwd_sel           : per source: 0 = register file, k = tag stage k-1
//   stall             : load-use stall (hold front end, bubble into EX/MEM)
//   stall_cnt         : saturating count of taken stall cycles
//                       (present only when FWD_PERF_CNT_EN is defined)
//
// Optional feature macro: FWD_PERF_CNT_EN
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int NUM_SRC          = 3,
  parameter int REG_BITS         = 5,
  parameter int ZERO_REG         = 31,
  parameter int FWD_DEPTH        = 2,
  parameter int LOAD_READY_STAGE = 1,
  parameter int SEL_W            = $clog2(FWD_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ex_valid,
  input  logic [REG_BITS-1:0]         ex_rd,
  input  logic                        ex_regwrite,
  input  logic                        ex_is_load,
  input  logic [NUM_SRC*REG_BITS-1:0] ex_src,
  input  logic [NUM_SRC-1:0]          ex_src_used,
  input  logic                        ext_hold,
  input  logic                        flush,
  output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
`ifdef FWD_PERF_CNT_EN
  output logic                        stall,
  output logic [31:0]                 stall_cnt
`else
  output logic                        stall
`endif
);

  typedef struct packed {
    logic                valid;
    logic [REG_BITS-1:0] rd;
    logic                regwrite;
    logic                is_load;
  } tag_t;

  tag_t tag_q [FWD_DEPTH];
  tag_t tag_d [FWD_DEPTH];

  logic [NUM_SRC*SEL_W-1:0] sel_raw;
  logic [NUM_SRC-1:0]       src_stall;

  // Scan from the oldest stage down to stage 0 so that the youngest matching
  // producer overwrites any older one. The stall contribution of a source is
  // taken from that same youngest match, so an older load never stalls when a
  // younger non-load producer exists.
  always_comb begin
    sel_raw   = '0;
    src_stall = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int s = FWD_DEPTH - 1; s >= 0; s--) begin
        if (ex_valid && ex_src_used[i] && tag_q[s].valid && tag_q[s].regwrite &&
            (tag_q[s].rd != REG_BITS'(ZERO_REG)) &&
            (tag_q[s].rd == ex_src[i*REG_BITS +: REG_BITS])) begin
          sel_raw[i*SEL_W +: SEL_W] = SEL_W'(s + 1);
          src_stall[i]              = tag_q[s].is_load && (s < LOAD_READY_STAGE);
        end
      end
    end
  end

  // Reset forces the outputs quiet combinationally; a flush kills the
  // consumer, so no hazard exists for it.
  assign fwd_sel = reset ? '0 : sel_raw;
  assign stall   = ~reset & ~flush & (|src_stall);

  // Tag pipeline next state. On a stall the EX instruction stays where it is
  // and a bubble enters stage 0 instead.
  always_comb begin
    for (int s = 0; s < FWD_DEPTH; s++) begin
      tag_d[s] = tag_q[s];
    end
    if (!ext_hold) begin
      for (int s = FWD_DEPTH - 1; s >= 1; s--) begin
        tag_d[s] = tag_q[s-1];
      end
      if (stall) begin
        tag_d[0] = '0;
      end else begin
        tag_d[0] = {ex_valid & ~flush, ex_rd, ex_regwrite, ex_is_load};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < FWD_DEPTH; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < FWD_DEPTH; s++) begin
        tag_q[s] <= tag_d[s];
      end
    end
  end

`ifdef FWD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  // A stall during ext_hold does not take effect, so it is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall && !ext_hold && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised forwarding and load-use hazard unit for the pipelined LEGv8 core; evaluated against the instruction currently in EX.
- Keeps its own shadow pipeline of writer tags (valid, Rd, RegWrite, is_load), FWD_DEPTH stages deep, mirroring EX/MEM, MEM/WB and any further stages.
- Produces a forwarding select per source operand, for any number of operands.
- Raises a stall when the youngest producer is a load whose data is not yet available.

Parameters:
NUM_SRC, 3, number of source operands checked (Rn, Rm, store-data Rd).
REG_BITS, 5, register index width.
ZERO_REG, 31, register index never forwarded (XZR).
FWD_DEPTH, 2, number of forwarding stages after EX (stage 0 = EX/MEM).
LOAD_READY_STAGE, 1, first stage index at which a load's data may be forwarded.
SEL_W, $clog2(FWD_DEPTH+1), derived; width of each select field.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
ex_valid  in  1  EX holds a real (non-bubble) instruction.
ex_rd  in  REG_BITS  destination of EX instruction.
ex_regwrite  in  1  EX instruction writes ex_rd.
ex_is_load  in  1  EX instruction is a load.
ex_src  in  NUM_SRC*REG_BITS  source indices; field i = bits [i*REG_BITS +: REG_BITS].
ex_src_used  in  NUM_SRC  bit i set if source i is actually read.
ext_hold  in  1  global pipeline freeze (e.g. memory wait).
flush  in  1  kill EX instruction (branch redirect).
fwd_sel  out  NUM_SRC*SEL_W  per source: 0 = register file, k = stage k-1.
stall  out  1  load-use stall; hold IF/ID/ID-EX and inject bubble into EX/MEM.

Behaviour:
- Clock and reset: single clock clk. reset is synchronous, active-high, sampled on rising edge.
  - Reset clears all tag valid bits.
  - While reset is high, fwd_sel = 0 and stall = 0, forced combinationally.
- Tag match: stage s matches source i when all of the following hold:
  - tag valid, tag RegWrite, tag Rd != ZERO_REG, tag Rd == ex_src[i], ex_src_used[i], ex_valid.
- Forwarding select (combinational, zero latency): fwd_sel[i] = s+1 for the lowest matching s (youngest producer wins); 0 if no match.
- Load-use stall:
  - stall = 1 if any source's youngest match is a load tag in a stage s < LOAD_READY_STAGE.
  - Older matches never override the youngest match.
  - fwd_sel for a stalling source reports its youngest match anyway; the consumer ignores it while stall = 1.
- Tag pipeline update on each rising edge (first applicable rule wins):
  - reset: all stages invalid.
  - ext_hold = 1: all stages hold; no change.
  - stall = 1: stages 1..FWD_DEPTH-1 take stage 0..FWD_DEPTH-2; stage 0 becomes invalid (bubble). The EX instruction is not captured.
  - otherwise: shift; stage 0 captures {ex_valid & ~flush, ex_rd, ex_regwrite, ex_is_load}.
  - The last stage's tag is discarded. The register file performs write-before-read, so no forwarding is needed beyond FWD_DEPTH.
- flush = 1 forces stall = 0. flush has priority over a load-use hazard in the same cycle.
- ext_hold does not mask stall or fwd_sel. Outputs stay stable while held, because inputs and tags are stable.
- Stall duration: a load is stalled on for LOAD_READY_STAGE cycles (default 1), then fwd_sel = LOAD_READY_STAGE+1.
- ZERO_REG as a source never forwards and never stalls.
- ex_src_used = 0 on a source gives fwd_sel = 0 for it and no stall contribution.

Optional Feature:
Macro FWD_PERF_CNT_EN.
- Defined:
  - Adds output port stall_cnt (out, 32), reset to 0.
  - stall_cnt increments by 1 on each rising edge where stall = 1 and ext_hold = 0.
  - stall_cnt saturates at 32'hFFFF_FFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
All scenarios use default parameters.
1. Cycle n: ex_rd=1, ex_regwrite=1, ex_valid=1. Cycle n+1: ex_src[0]=1, used -> fwd_sel[0]=1. Cycle n+2 (same src, filler instr between) -> fwd_sel[0]=2. Cycle n+3 -> 0. stall stays 0 throughout.
2. Stage 0 and stage 1 both write X2; ex_src[1]=2 -> fwd_sel[1]=1 (youngest). Same setup with ex_rd=31 in both -> fwd_sel[1]=0.
3. LDUR X3 in EX, then a consumer with ex_src[0]=3 -> stall=1 for exactly one cycle and stage 0 goes invalid. Next cycle stall=0, fwd_sel[0]=2.
4. Load-use hazard with flush=1 in the same cycle -> stall=0, and stage 0 invalid on the next edge. Load-use with ex_src_used[0]=0 -> stall=0.
5. Producer X4 in stage 0, consumer reading X4, ext_hold=1 for 3 cycles -> fwd_sel[0]=1 stable all 3 cycles. Release -> tags advance one stage.
6. Tags populated, assert reset for one cycle -> fwd_sel=0 and stall=0 during reset and on the following cycle. With FWD_PERF_CNT_EN, 3 stall cycles -> stall_cnt=3, then 0 after reset.
